// File: rtl/i2c_pkg.sv
// Shared state encoding and bus constants for the I2C register target.
package i2c_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_PTR,
      ST_PTR_ACK,
      ST_WDATA,
      ST_WDATA_ACK,
      ST_RDATA,
      ST_RACK,
      ST_IGNORE
   } state_t;

   localparam int unsigned SYNC_DEPTH = 2;
   localparam logic        RW_READ    = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronises SCL/SDA into the clk domain and derives edge and START/STOP events.
module i2c_bus_sync
   import i2c_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic scl,
   input  logic sda,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det,
   output logic sda_s
);

   logic [SYNC_DEPTH-1:0] scl_sync;
   logic [SYNC_DEPTH-1:0] sda_sync;
   logic                  scl_s;
   logic                  scl_d;
   logic                  sda_d;

   // Flops reset high so an idle bus produces no events after reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scl_sync <= '1;
         sda_sync <= '1;
         scl_d    <= 1'b1;
         sda_d    <= 1'b1;
      end else begin
         scl_sync <= {scl_sync[SYNC_DEPTH-2:0], scl};
         sda_sync <= {sda_sync[SYNC_DEPTH-2:0], sda};
         scl_d    <= scl_s;
         sda_d    <= sda_s;
      end
   end

   assign scl_s     = scl_sync[SYNC_DEPTH-1];
   assign sda_s     = sda_sync[SYNC_DEPTH-1];
   assign scl_rise  = scl_s & ~scl_d;
   assign scl_fall  = ~scl_s & scl_d;
   assign start_det = scl_s & scl_d & sda_d & ~sda_s;
   assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

endmodule

// File: rtl/i2c_slave.sv
// I2C target mapping write/read transfers onto an auto-incrementing register port.
module i2c_slave
   import i2c_pkg::*;
#(
   parameter logic [6:0]  SLAVE_ADDR = 7'h50,
   parameter int unsigned REG_AW     = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              scl,
   inout  logic              sda,
   output logic [REG_AW-1:0] reg_addr,
   output logic [7:0]        reg_wdata,
   output logic              reg_we,
   input  logic [7:0]        reg_rdata,
   output logic              active,
   output logic              stop_pulse
);

   logic scl_rise, scl_fall, start_det, stop_det, sda_s;

   state_t            state, state_n;
   logic [2:0]        bit_cnt, bit_cnt_n;
   logic [7:0]        shreg, shreg_n, byte_in;
   logic              rw, rw_n;
   logic              sda_oe, sda_oe_n;
   logic [REG_AW-1:0] addr_n;
   logic [7:0]        wdata_n;
   logic              we_n, active_n, stop_n, byte_done;

   i2c_bus_sync u_sync (
      .clk       (clk),
      .rst       (rst),
      .scl       (scl),
      .sda       (sda),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det),
      .sda_s     (sda_s)
   );

   assign sda = sda_oe ? 1'b0 : 1'bz;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         bit_cnt    <= '0;
         shreg      <= '0;
         rw         <= 1'b0;
         sda_oe     <= 1'b0;
         reg_addr   <= '0;
         reg_wdata  <= '0;
         reg_we     <= 1'b0;
         active     <= 1'b0;
         stop_pulse <= 1'b0;
      end else begin
         state      <= state_n;
         bit_cnt    <= bit_cnt_n;
         shreg      <= shreg_n;
         rw         <= rw_n;
         sda_oe     <= sda_oe_n;
         reg_addr   <= addr_n;
         reg_wdata  <= wdata_n;
         reg_we     <= we_n;
         active     <= active_n;
         stop_pulse <= stop_n;
      end
   end

   assign byte_in   = {shreg[6:0], sda_s};
   assign byte_done = scl_rise && (bit_cnt == 3'd7);

   always_comb begin
      state_n   = state;
      bit_cnt_n = bit_cnt;
      shreg_n   = shreg;
      rw_n      = rw;
      sda_oe_n  = sda_oe;
      addr_n    = reg_addr;
      wdata_n   = reg_wdata;
      we_n      = 1'b0;
      active_n  = active;
      stop_n    = 1'b0;
      if (reg_we)
         addr_n = reg_addr + REG_AW'(1);
      if (start_det) begin
         state_n   = ST_ADDR;
         bit_cnt_n = '0;
         sda_oe_n  = 1'b0;
         active_n  = 1'b0;
      end else if (stop_det) begin
         state_n   = ST_IDLE;
         bit_cnt_n = '0;
         sda_oe_n  = 1'b0;
         active_n  = 1'b0;
         stop_n    = 1'b1;
      end else begin
         if (scl_rise && (state inside {ST_ADDR, ST_PTR, ST_WDATA, ST_RDATA})) begin
            shreg_n   = byte_in;
            bit_cnt_n = bit_cnt + 3'd1;
         end
         case (state)
            ST_ADDR: if (byte_done) begin
               if (byte_in[7:1] == SLAVE_ADDR && byte_in[7:1] != 7'h00) begin
                  state_n  = ST_ADDR_ACK;
                  rw_n     = byte_in[0];
                  active_n = 1'b1;
               end else begin
                  state_n = ST_IGNORE;
               end
            end
            ST_PTR: if (byte_done) begin
               addr_n  = byte_in[REG_AW-1:0];
               state_n = ST_PTR_ACK;
            end
            ST_WDATA: if (byte_done) begin
               wdata_n = byte_in;
               we_n    = 1'b1;
               state_n = ST_WDATA_ACK;
            end
            // First fall asserts the ACK, the second fall ends the ACK period.
            ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: if (scl_fall) begin
               if (!sda_oe) begin
                  sda_oe_n = 1'b1;
               end else begin
                  sda_oe_n  = 1'b0;
                  bit_cnt_n = '0;
                  if (state != ST_ADDR_ACK) begin
                     state_n = ST_WDATA;
                  end else if (rw != RW_READ) begin
                     state_n = ST_PTR;
                  end else begin
                     state_n  = ST_RDATA;
                     shreg_n  = reg_rdata;
                     sda_oe_n = ~reg_rdata[7];
                  end
               end
            end
            ST_RDATA: begin
               if (byte_done)
                  state_n = ST_RACK;
               else if (scl_fall)
                  sda_oe_n = ~shreg[7];
            end
            // bit_cnt doubles as the "master ACKed" marker during RACK.
            ST_RACK: begin
               if (scl_rise) begin
                  if (sda_s) begin
                     state_n  = ST_IGNORE;
                     active_n = 1'b0;
                  end else begin
                     addr_n    = reg_addr + REG_AW'(1);
                     bit_cnt_n = 3'd1;
                  end
               end else if (scl_fall) begin
                  if (bit_cnt == 3'd1) begin
                     state_n   = ST_RDATA;
                     bit_cnt_n = '0;
                     shreg_n   = reg_rdata;
                     sda_oe_n  = ~reg_rdata[7];
                  end else begin
                     sda_oe_n = 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bus-level bench for i2c_slave with a transaction-level register model.
module tb_i2c_slave;

   localparam int Q = 80;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       scl = 1'b1;
   logic       m_sda_low = 1'b0;
   wire        sda_bus;
   logic [3:0] reg_addr;
   logic [7:0] reg_wdata;
   logic [7:0] reg_rdata;
   logic       reg_we, active, stop_pulse;

   int checks = 0;
   int failures = 0;

   int          mdl_ptr = 0;
   bit          mdl_sel = 1'b0;
   bit          mdl_first = 1'b0;
   bit          expect_quiet = 1'b0;
   int          exp_stops = 0;
   int          stops_seen = 0;
   logic [11:0] exp_q[$];
   logic [11:0] we_log[$];

   assign sda_bus = m_sda_low ? 1'b0 : 1'bz;
   pullup (sda_bus);
   assign reg_rdata = 8'hC0 + {4'h0, reg_addr};

   always #5 clk = ~clk;

   i2c_slave #(.SLAVE_ADDR(7'h50), .REG_AW(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .scl        (scl),
      .sda        (sda_bus),
      .reg_addr   (reg_addr),
      .reg_wdata  (reg_wdata),
      .reg_we     (reg_we),
      .reg_rdata  (reg_rdata),
      .active     (active),
      .stop_pulse (stop_pulse)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic int wl(input int i);
      if (i < we_log.size()) return int'(we_log[i]);
      return -1;
   endfunction

   task automatic monitor();
      logic we_prev = 1'b0;
      logic sp_prev = 1'b0;
      int   e;
      forever begin
         @(negedge clk);
         if (reg_we) begin
            we_log.push_back({reg_addr, reg_wdata});
            e = (exp_q.size() != 0) ? int'(exp_q.pop_front()) : -1;
            chk("we_value", int'({reg_addr, reg_wdata}), e);
            chk("we_width", int'(we_prev), 0);
         end
         if (stop_pulse) begin
            stops_seen++;
            chk("stop_width", int'(sp_prev), 0);
         end
         if (expect_quiet && !m_sda_low) begin
            chk("quiet_sda", int'(sda_bus), 1);
            chk("quiet_active", int'(active), 0);
         end
         we_prev = reg_we;
         sp_prev = stop_pulse;
      end
   endtask

   task automatic start_cond();
      m_sda_low = 1'b0; #Q;
      scl = 1'b1;       #Q;
      m_sda_low = 1'b1; #Q;
      scl = 1'b0;       #Q;
   endtask

   task automatic write_bit(input logic b);
      m_sda_low = ~b; #Q;
      scl = 1'b1;     #(2*Q);
      scl = 1'b0;     #Q;
   endtask

   task automatic read_bit(output logic b);
      m_sda_low = 1'b0; #Q;
      scl = 1'b1;       #Q;
      b = sda_bus;      #Q;
      scl = 1'b0;       #Q;
   endtask

   task automatic write_bits(input logic [7:0] b, input int n);
      for (int i = 7; i > 7 - n; i--) write_bit(b[i]);
   endtask

   task automatic write_byte(input logic [7:0] b, output logic ack);
      write_bits(b, 8);
      read_bit(ack);
   endtask

   task automatic read_byte(input bit mack, output logic [7:0] d);
      for (int i = 7; i >= 0; i--) read_bit(d[i]);
      write_bit(~mack);
   endtask

   task automatic m_addr(input logic [7:0] b);
      logic ack;
      start_cond();
      write_byte(b, ack);
      mdl_sel   = (b[7:1] == 7'h50);
      mdl_first = 1'b1;
      chk("addr_ack_level", int'(ack), mdl_sel ? 0 : 1);
      chk("addr_active", int'(active), int'(mdl_sel));
   endtask

   task automatic m_wr(input logic [7:0] b);
      logic ack;
      if (mdl_sel) begin
         if (mdl_first) begin
            mdl_ptr = int'(b[3:0]);
         end else begin
            exp_q.push_back({4'(mdl_ptr), b});
            mdl_ptr = (mdl_ptr + 1) % 16;
         end
      end
      mdl_first = 1'b0;
      write_byte(b, ack);
      chk("wr_ack_level", int'(ack), mdl_sel ? 0 : 1);
   endtask

   task automatic m_rd(input bit mack, output logic [7:0] d);
      int exp;
      exp = 8'hC0 + mdl_ptr;
      read_byte(mack, d);
      chk("rd_data", int'(d), exp);
      if (mack) mdl_ptr = (mdl_ptr + 1) % 16;
      else      mdl_sel = 1'b0;
      chk("rd_active", int'(active), int'(mdl_sel));
   endtask

   task automatic m_stop();
      m_sda_low = 1'b1; #Q;
      scl = 1'b1;       #Q;
      m_sda_low = 1'b0; #Q;
      exp_stops++;
      mdl_sel = 1'b0;
      chk("stop_count", stops_seen, exp_stops);
      chk("stop_active", int'(active), 0);
      chk("ptr", int'(reg_addr), mdl_ptr);
      chk("we_missing", exp_q.size(), 0);
   endtask

   initial begin
      logic [7:0] d0, d1;
      logic       b;
      fork
         monitor();
      join_none

      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("rst_addr", int'(reg_addr), 0);
      chk("rst_wdata", int'(reg_wdata), 0);
      chk("rst_we", int'(reg_we), 0);
      chk("rst_active", int'(active), 0);
      chk("rst_stop", int'(stop_pulse), 0);
      chk("rst_sda", int'(sda_bus), 1);
      rst = 1'b1;
      repeat (10) @(negedge clk);
      chk("idle_stop", stops_seen, 0);

      // write: pointer 3, two data bytes
      we_log.delete();
      m_addr(8'hA0); m_wr(8'h03); m_wr(8'hA5); m_wr(8'h5A); m_stop();
      chk("lit_w_count", we_log.size(), 2);
      chk("lit_w0", wl(0), 'h3A5);
      chk("lit_w1", wl(1), 'h45A);
      chk("lit_w_addr", int'(reg_addr), 5);
      chk("lit_w_stops", stops_seen, 1);

      // read through repeated START
      we_log.delete();
      m_addr(8'hA0); m_wr(8'h02); m_addr(8'hA1);
      m_rd(1'b1, d0); m_rd(1'b0, d1);
      chk("rd_release", int'(sda_bus), 1);
      m_stop();
      chk("lit_r0", int'(d0), 'hC2);
      chk("lit_r1", int'(d1), 'hC3);
      chk("lit_r_nowe", we_log.size(), 0);
      chk("lit_r_addr", int'(reg_addr), 3);

      // address mismatch
      we_log.delete();
      expect_quiet = 1'b1;
      m_addr(8'hA2); m_wr(8'h33); m_stop();
      expect_quiet = 1'b0;
      chk("lit_m_nowe", we_log.size(), 0);

      // pointer wrap
      we_log.delete();
      m_addr(8'hA0); m_wr(8'h0F); m_wr(8'h11); m_wr(8'h22); m_stop();
      chk("lit_wrap0", wl(0), 'hF11);
      chk("lit_wrap1", wl(1), 'h022);
      chk("lit_wrap_addr", int'(reg_addr), 1);

      // STOP mid-byte, then a normal transfer
      we_log.delete();
      m_addr(8'hA0); m_wr(8'h01); write_bits(8'hF0, 4); m_stop();
      chk("lit_part_nowe", we_log.size(), 0);
      chk("lit_part_addr", int'(reg_addr), 1);
      m_addr(8'hA0); m_wr(8'h07); m_wr(8'h3C); m_stop();
      chk("lit_after_part", wl(0), 'h73C);
      chk("lit_after_addr", int'(reg_addr), 8);

      // reset while ACK is driven
      start_cond();
      write_bits(8'hA0, 8);
      m_sda_low = 1'b0;
      #20;
      chk("ack_driven", int'(sda_bus), 0);
      chk("ack_active", int'(active), 1);
      rst = 1'b0;
      #1;
      chk("rst_async_release", int'(sda_bus), 1);
      @(negedge clk);
      chk("mid_rst_addr", int'(reg_addr), 0);
      chk("mid_rst_wdata", int'(reg_wdata), 0);
      chk("mid_rst_we", int'(reg_we), 0);
      chk("mid_rst_active", int'(active), 0);
      chk("mid_rst_stop", int'(stop_pulse), 0);
      mdl_ptr = 0;
      mdl_sel = 1'b0;
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst = 1'b1;
      expect_quiet = 1'b1;
      scl = 1'b1; #(2*Q);
      scl = 1'b0; #Q;
      write_bits(8'hA0, 8);
      read_bit(b);
      chk("post_rst_nack", int'(b), 1);
      expect_quiet = 1'b0;
      m_addr(8'hA0); m_wr(8'h09); m_stop();
      chk("lit_post_rst_addr", int'(reg_addr), 9);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
